// File: rtl/udp_pixel_unpacker.sv
// udp_pixel_unpacker: UDP payload bytes -> tagged pixel words via output FIFO.
// Optional big-endian line-index header, short-packet and overflow reporting.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_udp_rx_valid/last/data  payload byte stream (no backpressure)
//   o_pix_data/line/first/last/valid, i_pix_ready  FIFO head, valid/ready
//   o_err_short               1-cycle pulse, packet ended mid header/pixel
//   o_err_overflow            sticky, a pixel was dropped on a full FIFO
module udp_pixel_unpacker #(
   parameter int BYTES_PER_PIXEL = 3,
   parameter int HDR_BYTES       = 2,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_udp_rx_valid,
   input  logic                         i_udp_rx_last,
   input  logic [7:0]                   i_udp_rx_data,
   output logic [8*BYTES_PER_PIXEL-1:0] o_pix_data,
   output logic [15:0]                  o_pix_line,
   output logic                         o_pix_first,
   output logic                         o_pix_last,
   output logic                         o_pix_valid,
   input  logic                         i_pix_ready,
   output logic                         o_err_short,
   output logic                         o_err_overflow
);

   localparam int PIX_W = 8 * BYTES_PER_PIXEL;
   localparam int BC_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int ENT_W = PIX_W + 18;

   localparam logic [BC_W-1:0] BC_LAST  = BC_W'(BYTES_PER_PIXEL - 1);
   localparam logic [1:0]      HDR_LAST = (HDR_BYTES > 0) ? 2'(HDR_BYTES - 1) : 2'd0;
   localparam logic [AW:0]     FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_HDR,
      S_PIX,
      S_DROP
   } state_t;

   localparam state_t S_IDLE = (HDR_BYTES > 0) ? S_HDR : S_PIX;

   state_t            r_state;
   logic [1:0]        r_hdr_cnt;
   logic [7:0]        r_hdr_lo;
   logic [15:0]       r_line;
   logic [BC_W-1:0]   r_bcnt;
   logic [PIX_W-1:0]  r_pix;
   logic              r_first;
   logic              r_err_short;
   logic              r_err_ovf;

   logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_cnt;

   state_t            w_state_nxt;
   logic [1:0]        w_hdr_cnt_nxt;
   logic [7:0]        w_hdr_lo_nxt;
   logic [15:0]       w_line_nxt;
   logic [BC_W-1:0]   w_bcnt_nxt;
   logic [PIX_W-1:0]  w_pix_reg_nxt;
   logic              w_first_nxt;
   logic              w_push;
   logic              w_drop;
   logic              w_short;

   logic [PIX_W+7:0]  w_pix_cat;
   logic [PIX_W-1:0]  w_pix_shift;
   logic              w_pop;
   logic              w_space;
   logic [ENT_W-1:0]  w_entry;
   logic [ENT_W-1:0]  w_head;

   // Shift the new byte in at the LSB; after BYTES_PER_PIXEL shifts the
   // first byte of the pixel has reached the MSB.
   assign w_pix_cat   = {r_pix, i_udp_rx_data};
   assign w_pix_shift = w_pix_cat[PIX_W-1:0];

   // A same-cycle pop frees a slot for the incoming pixel.
   assign w_pop   = (r_cnt != '0) && i_pix_ready;
   assign w_space = (r_cnt != FULL_CNT) || w_pop;

   assign w_entry = {r_first, i_udp_rx_last, r_line, w_pix_shift};

   always_comb begin
      w_state_nxt   = r_state;
      w_hdr_cnt_nxt = r_hdr_cnt;
      w_hdr_lo_nxt  = r_hdr_lo;
      w_line_nxt    = r_line;
      w_bcnt_nxt    = r_bcnt;
      w_pix_reg_nxt = r_pix;
      w_first_nxt   = r_first;
      w_push        = 1'b0;
      w_drop        = 1'b0;
      w_short       = 1'b0;
      if (i_udp_rx_valid) begin
         unique case (r_state)
            S_HDR: begin
               if (r_hdr_cnt == HDR_LAST) begin
                  // r_hdr_lo is still 0 for a 1-byte header: zero-extend.
                  w_line_nxt    = {r_hdr_lo, i_udp_rx_data};
                  w_hdr_lo_nxt  = 8'd0;
                  w_hdr_cnt_nxt = 2'd0;
                  w_state_nxt   = S_PIX;
               end else begin
                  w_hdr_lo_nxt  = i_udp_rx_data;
                  w_hdr_cnt_nxt = r_hdr_cnt + 2'd1;
               end
               if (i_udp_rx_last) begin
                  w_short       = 1'b1;
                  w_hdr_lo_nxt  = 8'd0;
                  w_hdr_cnt_nxt = 2'd0;
                  w_first_nxt   = 1'b1;
                  w_state_nxt   = S_IDLE;
               end
            end
            S_PIX: begin
               w_pix_reg_nxt = w_pix_shift;
               if (r_bcnt == BC_LAST) begin
                  w_bcnt_nxt  = '0;
                  w_first_nxt = 1'b0;
                  if (w_space) begin
                     w_push = 1'b1;
                  end else begin
                     w_drop = 1'b1;
                     if (!i_udp_rx_last) begin
                        w_state_nxt = S_DROP;
                     end
                  end
               end else begin
                  w_bcnt_nxt = r_bcnt + 1'b1;
               end
               if (i_udp_rx_last) begin
                  w_short     = (r_bcnt != BC_LAST);
                  w_bcnt_nxt  = '0;
                  w_first_nxt = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_DROP: begin
               if (i_udp_rx_last) begin
                  w_first_nxt = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_hdr_cnt   <= 2'd0;
         r_hdr_lo    <= 8'd0;
         r_line      <= 16'd0;
         r_bcnt      <= '0;
         r_pix       <= '0;
         r_first     <= 1'b1;
         r_err_short <= 1'b0;
         r_err_ovf   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hdr_cnt   <= w_hdr_cnt_nxt;
         r_hdr_lo    <= w_hdr_lo_nxt;
         r_line      <= w_line_nxt;
         r_bcnt      <= w_bcnt_nxt;
         r_pix       <= w_pix_reg_nxt;
         r_first     <= w_first_nxt;
         r_err_short <= w_short;
         r_err_ovf   <= r_err_ovf | w_drop;
      end
   end

   // Storage needs no reset: o_pix_* are masked while the FIFO is empty.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_entry;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (w_pop && !w_push) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign w_head = r_mem[r_rptr];

   assign o_pix_valid    = (r_cnt != '0);
   assign o_pix_data     = o_pix_valid ? w_head[PIX_W-1:0] : '0;
   assign o_pix_line     = o_pix_valid ? w_head[PIX_W+15:PIX_W] : 16'd0;
   assign o_pix_last     = o_pix_valid & w_head[PIX_W+16];
   assign o_pix_first    = o_pix_valid & w_head[PIX_W+17];
   assign o_err_short    = r_err_short;
   assign o_err_overflow = r_err_ovf;

endmodule

// File: tb/tb_udp_pixel_unpacker.sv
// tb_udp_pixel_unpacker: directed + scoreboard bench for udp_pixel_unpacker.
// DUT a: 3 B/pixel, 2 B header, depth 4.  DUT b: 1 B/pixel, no header.
module tb_udp_pixel_unpacker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst_n, a_valid, a_last, a_ready;
   logic [7:0]  a_data;
   logic [23:0] a_pix;
   logic [15:0] a_line;
   logic        a_first, a_plast, a_pvalid, a_short, a_ovf;

   logic        b_rst_n, b_valid, b_last;
   logic        b_ready = 1'b1;
   logic [7:0]  b_data;
   logic [7:0]  b_pix;
   logic [15:0] b_line;
   logic        b_first, b_plast, b_pvalid, b_short, b_ovf;

   logic        rand_en = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   logic [63:0] q_a[$];
   logic [63:0] q_b[$];

   udp_pixel_unpacker #(
      .BYTES_PER_PIXEL(3), .HDR_BYTES(2), .FIFO_DEPTH(4)
   ) u_a (
      .i_clk(clk), .i_rst_n(a_rst_n),
      .i_udp_rx_valid(a_valid), .i_udp_rx_last(a_last),
      .i_udp_rx_data(a_data),
      .o_pix_data(a_pix), .o_pix_line(a_line),
      .o_pix_first(a_first), .o_pix_last(a_plast),
      .o_pix_valid(a_pvalid), .i_pix_ready(a_ready),
      .o_err_short(a_short), .o_err_overflow(a_ovf)
   );

   udp_pixel_unpacker #(
      .BYTES_PER_PIXEL(1), .HDR_BYTES(0), .FIFO_DEPTH(4)
   ) u_b (
      .i_clk(clk), .i_rst_n(b_rst_n),
      .i_udp_rx_valid(b_valid), .i_udp_rx_last(b_last),
      .i_udp_rx_data(b_data),
      .o_pix_data(b_pix), .o_pix_line(b_line),
      .o_pix_first(b_first), .o_pix_last(b_plast),
      .o_pix_valid(b_pvalid), .i_pix_ready(b_ready),
      .o_err_short(b_short), .o_err_overflow(b_ovf)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] ea(input logic f, input logic l,
                                      input logic [15:0] ln,
                                      input logic [23:0] p);
      return {22'd0, f, l, ln, p};
   endfunction

   function automatic logic [63:0] eb(input logic f, input logic l,
                                      input logic [7:0] p);
      return {38'd0, f, l, 16'd0, p};
   endfunction

   always @(negedge clk) begin
      if (a_pvalid && a_ready) begin
         check("a_q_nonempty", 64'(q_a.size() != 0), 64'd1);
         if (q_a.size() != 0)
            check("a_pix", {22'd0, a_first, a_plast, a_line, a_pix},
                  q_a.pop_front());
      end
      if (b_pvalid && b_ready) begin
         check("b_q_nonempty", 64'(q_b.size() != 0), 64'd1);
         if (q_b.size() != 0)
            check("b_pix", {38'd0, b_first, b_plast, b_line, b_pix},
                  q_b.pop_front());
      end
   end

   always @(posedge clk) begin
      #1;
      b_ready = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic byte_a(input logic [7:0] d, input logic l);
      a_valid = 1'b1;
      a_data  = d;
      a_last  = l;
      tick();
      a_valid = 1'b0;
      a_last  = 1'b0;
   endtask

   task automatic pix_a(input logic [23:0] p, input logic l);
      byte_a(p[23:16], 1'b0);
      byte_a(p[15:8], 1'b0);
      byte_a(p[7:0], l);
   endtask

   task automatic drain_a(input string tag);
      int g;
      g = 0;
      while (q_a.size() != 0 && g < 50) begin
         tick();
         g++;
      end
      check(tag, 64'(q_a.size()), 64'd0);
   endtask

   task automatic send_b(input logic [7:0] d, input logic l, input logic f);
      int g;
      g = 0;
      while (q_b.size() >= 3 && g < 200) begin
         tick();
         g++;
      end
      check("b_wait", 64'(g < 200), 64'd1);
      q_b.push_back(eb(f, l, d));
      b_valid = 1'b1;
      b_data  = d;
      b_last  = l;
      tick();
      b_valid = 1'b0;
      b_last  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [23:0] p;
      int len;
      int g;
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      a_valid = 1'b0; a_last = 1'b0; a_data = 8'd0; a_ready = 1'b1;
      b_valid = 1'b0; b_last = 1'b0; b_data = 8'd0;
      tick(); tick();
      check("rst_valid", 64'(a_pvalid), 64'd0);
      check("rst_data",  64'(a_pix), 64'd0);
      check("rst_line",  64'(a_line), 64'd0);
      check("rst_flags", 64'({a_first, a_plast}), 64'd0);
      check("rst_errs",  64'({a_short, a_ovf}), 64'd0);
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      tick();
      check("rst_b_valid", 64'({b_pvalid, b_ovf, b_short}), 64'd0);

      // two pixels, line 5, one-cycle latency
      byte_a(8'h00, 1'b0); byte_a(8'h05, 1'b0);
      byte_a(8'h11, 1'b0); byte_a(8'h22, 1'b0);
      q_a.push_back(ea(1'b1, 1'b0, 16'd5, 24'h112233));
      byte_a(8'h33, 1'b0);
      check("t1_p0_valid", 64'(a_pvalid), 64'd1);
      check("t1_p0_data", 64'(a_pix), 64'h112233);
      q_a.push_back(ea(1'b0, 1'b1, 16'd5, 24'h445566));
      byte_a(8'h44, 1'b0); byte_a(8'h55, 1'b0);
      byte_a(8'h66, 1'b1);
      check("t1_p1_valid", 64'(a_pvalid), 64'd1);
      check("t1_p1_data", 64'(a_pix), 64'h445566);
      drain_a("t1_drain");

      // short packet, then clean packet
      byte_a(8'h00, 1'b0); byte_a(8'h07, 1'b0);
      byte_a(8'hAA, 1'b0); byte_a(8'hBB, 1'b1);
      check("t2_short_hi", 64'(a_short), 64'd1);
      check("t2_no_pix", 64'(a_pvalid), 64'd0);
      tick();
      check("t2_short_lo", 64'(a_short), 64'd0);
      q_a.push_back(ea(1'b1, 1'b1, 16'd8, 24'h010203));
      byte_a(8'h00, 1'b0); byte_a(8'h08, 1'b0);
      pix_a(24'h010203, 1'b1);
      check("t2_no_short", 64'(a_short), 64'd0);
      drain_a("t2_drain");

      // overflow: 6 pixels into depth 4 with ready low
      a_ready = 1'b0;
      byte_a(8'h00, 1'b0); byte_a(8'h09, 1'b0);
      for (int k = 0; k < 6; k++) begin
         p = {8'h10 + 8'(k), 8'h20 + 8'(k), 8'h30 + 8'(k)};
         if (k < 4) q_a.push_back(ea(k == 0, 1'b0, 16'd9, p));
         pix_a(p, k == 5);
         if (k == 3) check("t3_ovf_before", 64'(a_ovf), 64'd0);
         if (k == 4) check("t3_ovf_after", 64'(a_ovf), 64'd1);
      end
      check("t3_no_short", 64'(a_short), 64'd0);
      a_ready = 1'b1;
      drain_a("t3_drain");
      tick(); tick();
      check("t3_only4", 64'(a_pvalid), 64'd0);
      check("t3_ovf_sticky", 64'(a_ovf), 64'd1);
      a_rst_n = 1'b0; tick(); a_rst_n = 1'b1;
      check("t3_ovf_rst", 64'(a_ovf), 64'd0);

      // full FIFO with a pop in the completing cycle
      a_ready = 1'b0;
      byte_a(8'h00, 1'b0); byte_a(8'h0C, 1'b0);
      for (int k = 0; k < 4; k++) begin
         p = {8'h50 + 8'(k), 8'h60 + 8'(k), 8'h70 + 8'(k)};
         q_a.push_back(ea(k == 0, 1'b0, 16'd12, p));
         pix_a(p, 1'b0);
      end
      q_a.push_back(ea(1'b0, 1'b1, 16'd12, 24'hC0FFEE));
      byte_a(8'hC0, 1'b0); byte_a(8'hFF, 1'b0);
      a_ready = 1'b1;
      byte_a(8'hEE, 1'b1);
      a_ready = 1'b0;
      check("t4_no_ovf", 64'(a_ovf), 64'd0);
      check("t4_valid", 64'(a_pvalid), 64'd1);
      a_ready = 1'b1;
      drain_a("t4_drain");
      check("t4_no_ovf_end", 64'(a_ovf), 64'd0);

      // reset with 2 pixels queued and a partial pixel pending
      a_ready = 1'b0;
      byte_a(8'h00, 1'b0); byte_a(8'h03, 1'b0);
      pix_a(24'hA1A2A3, 1'b0);
      pix_a(24'hB1B2B3, 1'b0);
      byte_a(8'hCC, 1'b0);
      check("t5_queued", 64'(a_pvalid), 64'd1);
      a_rst_n = 1'b0; tick(); a_rst_n = 1'b1;
      check("t5_valid0", 64'(a_pvalid), 64'd0);
      check("t5_data0", 64'(a_pix), 64'd0);
      check("t5_line0", 64'(a_line), 64'd0);
      check("t5_flags0", 64'({a_first, a_plast, a_short, a_ovf}), 64'd0);
      a_ready = 1'b1;
      q_a.push_back(ea(1'b1, 1'b1, 16'h000A, 24'h0D0E0F));
      byte_a(8'h00, 1'b0); byte_a(8'h0A, 1'b0);
      pix_a(24'h0D0E0F, 1'b1);
      drain_a("t5_drain");

      // 1-byte pixels, no header, random ready
      rand_en = 1'b1;
      send_b(8'hA1, 1'b0, 1'b1);
      send_b(8'hA2, 1'b1, 1'b0);
      send_b(8'hB1, 1'b1, 1'b1);
      for (int pk = 0; pk < 8; pk++) begin
         len = int'($urandom_range(1, 5));
         for (int i = 0; i < len; i++)
            send_b(8'($urandom), i == len - 1, i == 0);
      end
      g = 0;
      while (q_b.size() != 0 && g < 500) begin
         tick();
         g++;
      end
      check("b_drain", 64'(q_b.size()), 64'd0);
      check("b_errs", 64'({b_ovf, b_short}), 64'd0);
      rand_en = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
